fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side adapter that drains a single-clock FIFO (1-cycle registered read latency) and presents its words on a valid/ready stream master port. It issues FIFO reads speculatively, tracks the read in flight, and absorbs the latency in a 2-entry output buffer. The result is full throughput (one word per cycle) with no word lost or duplicated under arbitrary downstream back-pressure. It sits between the FIFO and any consumer that applies back-pressure.

## Interface

- DW, 32, data width; must match the FIFO data width.
- CW, 32, width of the delivered-word counter.

- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- flush  in  1  synchronous flush; discards buffered and in-flight data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DW  FIFO read data, valid in the cycle after an accepted read.
- fifo_re  out  1  FIFO read enable.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DW  stream data.
- rd_cnt  out  CW  words delivered (m_valid & m_ready), wraps modulo 2^CW.

## Operation

- Reset (rst_n=0, asynchronous): occ=0, inflight=0, m_valid=0, m_data=0, rd_cnt=0, fifo_re=0.
- State: occ (0..2, buffered words), inflight (1 bit, a read was issued last cycle), 2-entry buffer with head/tail index.
- pop = m_valid & m_ready. m_valid = (occ != 0). m_data = buffer head.
- Read issue: fifo_re = rst_n & !flush & !fifo_empty & ((occ + inflight - pop) < 2).
  - This creates a combinational path from m_ready to fifo_re, which is intended.
- inflight_next = fifo_re.
- Capture: if inflight and !flush, fifo_dout is written at the tail.
  - Capture and pop in the same cycle are both applied: occ unchanged, head and tail both advance.
- Overflow cannot occur by construction. The bench asserts occ ≤ 2 and no capture when occ = 2 without a pop.
- Flush: on the next edge, occ=0, inflight=0, and any word arriving on fifo_dout that cycle is discarded. fifo_re=0 while flush=1. rd_cnt is not cleared.
  - A pop in the flush cycle still counts in rd_cnt; the consumer saw the handshake.
- Stream rules: once m_valid=1, m_data holds stable until pop. m_valid never drops without a pop, except on flush or reset.
- rd_cnt increments by 1 on each pop and wraps from 2^CW-1 to 0.

## Timing

- First-word latency: fifo_re=1 in cycle N. fifo_dout is valid in N+1 and captured at the end of N+1. m_valid=1 in N+2.
- Steady state with m_ready=1 and FIFO non-empty: occ=1, inflight=1, fifo_re=1 and pop=1 every cycle, giving one word per cycle.
- Back-pressure (m_ready=0):
  - At most one more read is issued after occ+inflight reaches 2.
  - fifo_re drops in the cycle occ+inflight=2.
  - No read is issued while occ=2.
- Resume: when m_ready rises with occ=2, fifo_re may assert in that same cycle, so the pipeline stays full.
- fifo_empty rising while a read is in flight: the in-flight word is still captured. The FIFO guards re & empty, so fifo_re=1 on an empty FIFO is harmless but is never generated.
- Reset deassertion: the first fifo_re can assert in the first cycle after rst_n=1.

## Structure

- Shared package fifo_pkg: localparam BUF_DEPTH=2 and the occ type (2-bit).
- One sub-module, stream_buf2: the 2-entry buffer with push/pop/clear, occ, head data, and async active-low reset.
- fifo_rd_stream holds the issue logic, inflight flag, flush handling and rd_cnt.

## Test plan

- FIFO preloaded with 0x1..0x8, m_ready=1 -> m_data 0x1..0x8 on 8 consecutive cycles starting 2 cycles after the first fifo_re; rd_cnt=8; fifo_re high for exactly 8 cycles.
- FIFO holding 0x10..0x1F, m_ready toggling 1/0 each cycle -> all 16 words delivered in order exactly once; occ never exceeds 2; m_data stable whenever m_valid & !m_ready.
- 10 words, m_ready=0 for 20 cycles then 1 -> exactly 2 fifo_re pulses during the stall; the remaining 8 stream out back-to-back after release.
- flush asserted one cycle after a fifo_re with occ=1 -> the in-flight word and the buffered word are discarded; m_valid=0 next cycle; the next delivered word is the FIFO's following entry.
- rst_n pulsed low mid-stream, asynchronously between edges -> m_valid, fifo_re and rd_cnt go 0 immediately; after release, delivery restarts from the FIFO's current head.
- CW=4, 20 words delivered -> rd_cnt wraps and reads 4.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                             |
// | Shared constants and types for the FIFO read-side stream adapter.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_pkg;

  // Output buffer depth; two entries cover the 1-cycle FIFO read latency.
  localparam int BUF_DEPTH = 2;

  // Buffer occupancy, 0..BUF_DEPTH.
  typedef logic [1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_stream_if                                                    |
// | FIFO read port plus valid/ready stream bundle for fifo_rd_stream.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fifo_rd_stream_if #(
  parameter int DW = 32
);

  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  // Adapter side: drives the FIFO read enable and the stream outputs.
  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_re,
    output m_valid,
    output m_data
  );

  // Environment side: FIFO plus stream consumer.
  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_re,
    input  m_valid,
    input  m_data
  );

endinterface
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_buf2                                                          |
// | Two-entry circular buffer with push/pop/clear and occupancy.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output occ_t          occ,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem [BUF_DEPTH];
  logic          head;
  logic          tail;

  // Storage and pointers; push and pop in the same cycle both advance,
  // leaving occupancy unchanged. Clear drops all entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else if (clear) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ + occ_t'(push) - occ_t'(pop);
    end
  end

  assign head_data = mem[head];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_stream                                                       |
// | Drains a 1-cycle-latency FIFO onto a valid/ready stream at full     |
// | rate, issuing reads speculatively and tracking the one in flight.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  fifo_rd_stream_if.master     bus,
  output logic [CW-1:0]        rd_cnt
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic       push;
  logic [2:0] pending;

  assign pop          = bus.m_valid & bus.m_ready;
  assign bus.m_valid  = (occ != '0);

  // Words that will occupy the buffer after this edge if no new read is
  // issued. Depends on m_ready so a stalled, full buffer can restart
  // reading in the same cycle the consumer takes a word.
  assign pending      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign bus.fifo_re  = rst_n & ~flush & ~bus.fifo_empty & (pending < 3'd2);

  // A word lands on fifo_dout one cycle after its read; a flush in that
  // cycle throws it away.
  assign push         = inflight & ~flush;

  // Remember whether a read was issued, so its data is captured next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= bus.fifo_re;
    end
  end

  // Delivered-word counter; a handshake during flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  stream_buf2 #(
    .DW (DW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head_data (bus.m_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_rd_stream                                                    |
// | Directed self-checking bench for fifo_rd_stream.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] rd_cnt;
  logic [3:0]  rd_cnt4;

  fifo_rd_stream_if #(.DW(32)) bus  ();
  fifo_rd_stream_if #(.DW(32)) bus4 ();

  fifo_rd_stream #(.DW(32), .CW(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (bus),
    .rd_cnt (rd_cnt)
  );

  // Narrow-counter copy fed with identical inputs; only its counter is used.
  fifo_rd_stream #(.DW(32), .CW(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (bus4),
    .rd_cnt (rd_cnt4)
  );

  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_dout  = bus.fifo_dout;
  assign bus4.m_ready    = bus.m_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model, registered read data.
  logic [31:0] fmem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_re && (rd_ptr != wr_ptr)) begin
      bus.fifo_dout <= fmem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      fmem[wr_ptr[7:0]] = base + k;
      wr_ptr++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-phase statistics.
  logic [31:0] exp_next;
  int re_cnt, re_stall, delivered, first_re, first_pop, last_pop;

  // mode 0: ready=1 except ready=0 while i<stall; mode 1: ready toggles.
  task automatic run_phase(input int ncyc, input int mode, input int stall);
    logic        hold;
    logic [31:0] held;
    hold = 1'b0; held = '0;
    re_cnt = 0; re_stall = 0; delivered = 0;
    first_re = -1; first_pop = -1; last_pop = -1;
    for (int i = 0; i < ncyc; i++) begin
      bus.m_ready = (mode == 1) ? (i % 2 == 0) : (i >= stall);
      @(negedge clk);
      check_eq("occ_max", 64'(dut.u_buf.occ <= 2), 64'd1);
      if (hold) begin
        check_eq("hold_valid", 64'(bus.m_valid), 64'd1);
        check_eq("hold_data", 64'(bus.m_data), 64'(held));
      end
      if (bus.fifo_re) begin
        check_eq("re_not_empty", 64'(bus.fifo_empty), 64'd0);
        re_cnt++;
        if (i < stall) re_stall++;
        if (first_re < 0) first_re = i;
      end
      if (bus.m_valid && bus.m_ready) begin
        check_eq("data_order", 64'(bus.m_data), 64'(exp_next));
        exp_next++;
        delivered++;
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
      hold = bus.m_valid & ~bus.m_ready;
      held = bus.m_data;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
    load(32'h1, 8);
    step(); step();
    @(negedge clk);
    check_eq("rst_valid", 64'(bus.m_valid), 64'd0);
    check_eq("rst_data", 64'(bus.m_data), 64'd0);
    check_eq("rst_cnt", 64'(rd_cnt), 64'd0);
    check_eq("rst_re", 64'(bus.fifo_re), 64'd0);
    step();
    rst_n = 1'b1;

    // Full-rate streaming of 1..8.
    exp_next = 32'h1;
    run_phase(14, 0, 0);
    check_eq("p1_first_re", 64'(first_re), 64'd0);
    check_eq("p1_latency", 64'(first_pop - first_re), 64'd2);
    check_eq("p1_back2back", 64'(last_pop - first_pop), 64'd7);
    check_eq("p1_re_cnt", 64'(re_cnt), 64'd8);
    check_eq("p1_delivered", 64'(delivered), 64'd8);
    check_eq("p1_rd_cnt", 64'(rd_cnt), 64'd8);

    // Alternating back-pressure over 0x10..0x1F.
    load(32'h10, 16);
    exp_next = 32'h10;
    run_phase(60, 1, 0);
    check_eq("p2_delivered", 64'(delivered), 64'd16);
    check_eq("p2_last", 64'(exp_next), 64'h20);
    check_eq("p2_rd_cnt", 64'(rd_cnt), 64'd24);

    // Long stall then release.
    load(32'h100, 10);
    exp_next = 32'h100;
    run_phase(40, 0, 20);
    check_eq("p3_stall_re", 64'(re_stall), 64'd2);
    check_eq("p3_first_pop", 64'(first_pop), 64'd20);
    check_eq("p3_back2back", 64'(last_pop - first_pop), 64'd9);
    check_eq("p3_delivered", 64'(delivered), 64'd10);
    check_eq("p3_rd_cnt", 64'(rd_cnt), 64'd34);

    // Flush with one word buffered and one in flight.
    bus.m_ready = 1'b0;
    load(32'h200, 6);
    @(negedge clk);
    check_eq("p4_re_a", 64'(bus.fifo_re), 64'd1);
    step();
    @(negedge clk);
    check_eq("p4_re_b", 64'(bus.fifo_re), 64'd1);
    step();
    flush = 1'b1;
    @(negedge clk);
    check_eq("p4_re_flush", 64'(bus.fifo_re), 64'd0);
    check_eq("p4_valid_pre", 64'(bus.m_valid), 64'd1);
    check_eq("p4_data_pre", 64'(bus.m_data), 64'h200);
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("p4_valid_post", 64'(bus.m_valid), 64'd0);
    check_eq("p4_re_post", 64'(bus.fifo_re), 64'd1);
    step();
    exp_next = 32'h202;
    run_phase(12, 0, 0);
    check_eq("p4_delivered", 64'(delivered), 64'd4);
    check_eq("p4_rd_cnt", 64'(rd_cnt), 64'd38);

    // Asynchronous reset mid-stream.
    load(32'h300, 16);
    exp_next = 32'h300;
    run_phase(5, 0, 0);
    check_eq("p5_pre_delivered", 64'(delivered), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("p5_async_valid", 64'(bus.m_valid), 64'd0);
    check_eq("p5_async_re", 64'(bus.fifo_re), 64'd0);
    check_eq("p5_async_cnt", 64'(rd_cnt), 64'd0);
    check_eq("p5_async_data", 64'(bus.m_data), 64'd0);
    step(); step();
    rst_n = 1'b1;
    exp_next = 32'h305;
    run_phase(20, 0, 0);
    check_eq("p5_first_re", 64'(first_re), 64'd0);
    check_eq("p5_delivered", 64'(delivered), 64'd11);
    check_eq("p5_rd_cnt", 64'(rd_cnt), 64'd11);

    // Narrow counter wrap over 20 words.
    rst_n = 1'b0;
    load(32'h400, 20);
    step();
    rst_n = 1'b1;
    exp_next = 32'h400;
    run_phase(30, 0, 0);
    check_eq("p6_delivered", 64'(delivered), 64'd20);
    check_eq("p6_rd_cnt", 64'(rd_cnt), 64'd20);
    check_eq("p6_rd_cnt4", 64'(rd_cnt4), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
